// File: rtl/axis_video_meas.sv
// rtl/axis_video_meas.sv - passive AXI4-Stream video frame size/count/error tap
// Optional SOF-to-SOF period measurement enabled by defining VIDEO_MEAS_FPS_EN.
module axis_video_meas #(
    parameter int CNT_W = 12,
    parameter int FRM_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             TVALID,
    input  logic             TREADY,
    input  logic             TUSER,
    input  logic             TLAST,
    input  logic             meas_en_i,
    input  logic             clr_err_i,
    output logic [CNT_W-1:0] width_o,
    output logic [CNT_W-1:0] height_o,
    output logic [FRM_W-1:0] frame_cnt_o,
    output logic             meas_valid_o,
    output logic             line_err_o,
    output logic             sof_err_o
`ifdef VIDEO_MEAS_FPS_EN
    ,
    output logic [31:0]      frame_period_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_FRAME
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FRM_W-1:0] FRM_ONE = {{(FRM_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] line_cnt_q;
    logic [CNT_W-1:0] cur_width_q;

    logic             beat;
    logic             active;
    logic             sof_beat;
    logic             close_frame;
    logic             frame_beat;
    logic             first_line;
    logic             line_mis;
    logic             sof_mis;
    logic [CNT_W-1:0] pix_base;
    logic [CNT_W-1:0] pix_inc;
    logic [CNT_W-1:0] line_base;
    logic [CNT_W-1:0] line_inc;
    logic [CNT_W-1:0] width_base;

    assign beat        = TVALID & TREADY;
    assign active      = meas_en_i & (state_q != ST_IDLE);
    assign sof_beat    = active & beat & TUSER;
    assign close_frame = sof_beat & (state_q == ST_FRAME);
    assign frame_beat  = active & beat & (TUSER | (state_q == ST_FRAME));

    // An SOF beat is pixel 0 of a fresh frame, so per-frame counters restart from zero on it.
    assign pix_base   = sof_beat ? '0 : pix_cnt_q;
    assign line_base  = sof_beat ? '0 : line_cnt_q;
    assign width_base = sof_beat ? '0 : cur_width_q;
    assign pix_inc    = (pix_base == CNT_MAX) ? CNT_MAX : pix_base + CNT_ONE;
    assign line_inc   = (line_base == CNT_MAX) ? CNT_MAX : line_base + CNT_ONE;
    assign first_line = (line_base == '0);

    assign line_mis = frame_beat & TLAST & ~first_line & (pix_inc != cur_width_q);
    assign sof_mis  = close_frame & (pix_cnt_q != '0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (sof_beat) state_d = ST_FRAME;
            default:     state_d = state_q;
        endcase
        if (!meas_en_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            cur_width_q  <= '0;
            width_o      <= '0;
            height_o     <= '0;
            frame_cnt_o  <= '0;
            meas_valid_o <= 1'b0;
            line_err_o   <= 1'b0;
            sof_err_o    <= 1'b0;
        end else if (!meas_en_i) begin
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            cur_width_q  <= '0;
            width_o      <= '0;
            height_o     <= '0;
            frame_cnt_o  <= '0;
            meas_valid_o <= 1'b0;
            line_err_o   <= 1'b0;
            sof_err_o    <= 1'b0;
        end else begin
            if (frame_beat) begin
                if (TLAST) begin
                    pix_cnt_q  <= '0;
                    line_cnt_q <= line_inc;
                end else begin
                    pix_cnt_q  <= pix_inc;
                    line_cnt_q <= line_base;
                end
                cur_width_q <= (TLAST && first_line) ? pix_inc : width_base;
            end
            // Closing uses the pre-SOF registers, so the partial line is never counted.
            if (close_frame) begin
                width_o      <= cur_width_q;
                height_o     <= line_cnt_q;
                frame_cnt_o  <= frame_cnt_o + FRM_ONE;
                meas_valid_o <= 1'b1;
            end
            line_err_o <= line_mis | (line_err_o & ~clr_err_i);
            sof_err_o  <= sof_mis  | (sof_err_o  & ~clr_err_i);
        end
    end

`ifdef VIDEO_MEAS_FPS_EN
    logic [31:0] period_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            period_q       <= '0;
            frame_period_o <= '0;
        end else if (!meas_en_i) begin
            period_q       <= '0;
            frame_period_o <= '0;
        end else begin
            if (sof_beat) begin
                period_q <= 32'd1;
            end else if ((state_q == ST_FRAME) && (period_q != 32'hFFFF_FFFF)) begin
                period_q <= period_q + 32'd1;
            end
            if (close_frame) begin
                frame_period_o <= period_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_video_meas.sv
// tb/tb_axis_video_meas.sv - randomized self-checking bench for axis_video_meas
// Frame-level reference model; honours VIDEO_MEAS_FPS_EN when defined.
module tb_axis_video_meas;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        TVALID = 1'b0;
    logic        TREADY = 1'b0;
    logic        TUSER = 1'b0;
    logic        TLAST = 1'b0;
    logic        meas_en_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic [11:0] width_o;
    logic [11:0] height_o;
    logic [15:0] frame_cnt_o;
    logic        meas_valid_o;
    logic        line_err_o;
    logic        sof_err_o;
`ifdef VIDEO_MEAS_FPS_EN
    logic [31:0] frame_period_o;
`endif

    axis_video_meas dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .TVALID        (TVALID),
        .TREADY        (TREADY),
        .TUSER         (TUSER),
        .TLAST         (TLAST),
        .meas_en_i     (meas_en_i),
        .clr_err_i     (clr_err_i),
        .width_o       (width_o),
        .height_o      (height_o),
        .frame_cnt_o   (frame_cnt_o),
        .meas_valid_o  (meas_valid_o),
        .line_err_o    (line_err_o),
        .sof_err_o     (sof_err_o)
`ifdef VIDEO_MEAS_FPS_EN
        ,
        .frame_period_o(frame_period_o)
`endif
    );

    always #5 ACLK = ~ACLK;

    int tests  = 0;
    int failed = 0;
    int stall_pct = 0;
    bit rand_clr  = 1'b0;

    // Reference: completed line lengths of the open frame plus the pixels of the line in progress.
    int          m_mode;
    int          lines[$];
    int          partial;
    int          len;
    longint      cyc;
    longint      sof_cyc;
    bit          set_l;
    bit          set_s;
    logic [11:0] e_width;
    logic [11:0] e_height;
    logic [15:0] e_fcnt;
    logic        e_valid;
    logic        e_lerr;
    logic        e_serr;
    logic [31:0] e_period;

    task automatic model_clear();
        m_mode   = 0;
        lines.delete();
        partial  = 0;
        e_width  = '0;
        e_height = '0;
        e_fcnt   = '0;
        e_valid  = 1'b0;
        e_lerr   = 1'b0;
        e_serr   = 1'b0;
        e_period = '0;
    endtask

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            model_clear();
        end else begin
            cyc++;
            if (!meas_en_i) begin
                model_clear();
            end else begin
                set_l = 1'b0;
                set_s = 1'b0;
                if (m_mode == 0) begin
                    m_mode = 1;
                end else if (TVALID && TREADY) begin
                    if (TUSER && m_mode == 2) begin
                        e_width  = (lines.size() > 0) ? 12'(lines[0]) : 12'd0;
                        e_height = (lines.size() > 4095) ? 12'd4095 : 12'(lines.size());
                        e_fcnt   = e_fcnt + 16'd1;
                        e_valid  = 1'b1;
                        e_period = (cyc - sof_cyc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(cyc - sof_cyc);
                        if (partial > 0) set_s = 1'b1;
                    end
                    if (TUSER) begin
                        m_mode  = 2;
                        lines.delete();
                        partial = 0;
                        sof_cyc = cyc;
                    end
                    if (m_mode == 2) begin
                        partial++;
                        if (TLAST) begin
                            len = (partial > 4095) ? 4095 : partial;
                            if (lines.size() > 0 && len != lines[0]) set_l = 1'b1;
                            lines.push_back(len);
                            partial = 0;
                        end
                    end
                end
                e_lerr = set_l | (e_lerr & ~clr_err_i);
                e_serr = set_s | (e_serr & ~clr_err_i);
            end
        end
    end

    always @(negedge ACLK) begin
        if (ARESETn) begin
            tests++;
            if (width_o !== e_width || height_o !== e_height || frame_cnt_o !== e_fcnt ||
                meas_valid_o !== e_valid || line_err_o !== e_lerr || sof_err_o !== e_serr
`ifdef VIDEO_MEAS_FPS_EN
                || frame_period_o !== e_period
`endif
            ) begin
                failed++;
                $display("FAIL model_cmp t=%0t got w=%0d h=%0d n=%0d v=%0b le=%0b se=%0b expected w=%0d h=%0d n=%0d v=%0b le=%0b se=%0b",
                         $time, width_o, height_o, frame_cnt_o, meas_valid_o, line_err_o, sof_err_o,
                         e_width, e_height, e_fcnt, e_valid, e_lerr, e_serr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input bit v, input bit r, input bit u, input bit l);
        TVALID    = v;
        TREADY    = r;
        TUSER     = u;
        TLAST     = l;
        clr_err_i = rand_clr && ($urandom_range(0, 19) == 0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    task automatic beat(input bit u, input bit l);
        bit v;
        bit r;
        for (int tries = 0; tries < 16; tries++) begin
            if (stall_pct == 0 || tries >= 8) begin
                cycle(1'b1, 1'b1, u, l);
                return;
            end
            v = ($urandom_range(0, 99) >= stall_pct);
            r = ($urandom_range(0, 99) >= stall_pct);
            if (v && r) begin
                cycle(1'b1, 1'b1, u, l);
                return;
            end
            cycle(v, r, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    task automatic send_line(input int n, input bit sof, input bit last);
        for (int i = 0; i < n; i++) beat(sof && i == 0, last && i == n - 1);
    endtask

    task automatic send_frame(input int h, input int w);
        for (int i = 0; i < h; i++) send_line(w, i == 0, 1'b1);
    endtask

    task automatic pulse_clr();
        TVALID    = 1'b0;
        clr_err_i = 1'b1;
        @(posedge ACLK);
        #1;
        clr_err_i = 1'b0;
    endtask

    initial begin
        int h;
        int w;
        model_clear();
        cyc = 0;
        sof_cyc = 0;
        #22;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        check("reset_width", width_o, 0);
        check("reset_height", height_o, 0);
        check("reset_fcnt", frame_cnt_o, 0);
        check("reset_valid", meas_valid_o, 0);
        check("reset_errs", {line_err_o, sof_err_o}, 0);

        meas_en_i = 1'b1;
        idle(3);
        send_frame(10, 16);
        send_frame(10, 16);
        check("f2_width", width_o, 16);
        check("f2_height", height_o, 10);
        check("f2_valid", meas_valid_o, 1);
        check("f2_fcnt", frame_cnt_o, 1);
        send_frame(10, 16);
        check("f3_fcnt", frame_cnt_o, 2);
        check("f3_errs", {line_err_o, sof_err_o}, 0);
`ifdef VIDEO_MEAS_FPS_EN
        check("f3_period", frame_period_o, 160);
`endif

        stall_pct = 50;
        send_frame(10, 16);
        send_frame(10, 16);
        check("stall_width", width_o, 16);
        check("stall_height", height_o, 10);
        check("stall_fcnt", frame_cnt_o, 4);

        for (int i = 0; i < 3; i++) send_line(16, i == 0, 1'b1);
        send_line(15, 1'b0, 1'b1);
        check("line_err_set", line_err_o, 1);
        pulse_clr();
        check("line_err_clr", line_err_o, 0);
        for (int i = 4; i < 10; i++) send_line(16, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) send_line(16, i == 0, 1'b1);
        send_line(7, 1'b0, 1'b0);
        send_line(16, 1'b1, 1'b1);
        check("sof_err_set", sof_err_o, 1);
        check("sof_height", height_o, 5);
        check("sof_fcnt", frame_cnt_o, 7);
        for (int i = 1; i < 10; i++) send_line(16, 1'b0, 1'b1);
        pulse_clr();
        check("sof_err_clr", sof_err_o, 0);

        beat(1'b1, 1'b1);
        check("ul_width", width_o, 16);
        check("ul_height", height_o, 10);
        check("ul_fcnt", frame_cnt_o, 8);
        send_line(16, 1'b1, 1'b1);
        check("one_px_width", width_o, 1);
        check("one_px_height", height_o, 1);
        check("one_px_fcnt", frame_cnt_o, 9);
        check("one_px_sof_err", sof_err_o, 0);

        for (int i = 1; i < 4; i++) send_line(16, 1'b0, 1'b1);
        send_line(5, 1'b0, 1'b0);
        meas_en_i = 1'b0;
        idle(2);
        check("dis_width", width_o, 0);
        check("dis_fcnt", frame_cnt_o, 0);
        check("dis_valid", meas_valid_o, 0);
        meas_en_i = 1'b1;
        stall_pct = 30;
        send_line(5, 1'b0, 1'b1);
        send_line(3, 1'b0, 1'b0);
        check("wait_width", width_o, 0);
        check("wait_fcnt", frame_cnt_o, 0);
        send_frame(4, 8);
        send_frame(4, 8);
        check("reen_width", width_o, 8);
        check("reen_height", height_o, 4);
        check("reen_fcnt", frame_cnt_o, 1);
        check("reen_sof_err", sof_err_o, 0);

        stall_pct = 0;
        send_frame(2, 4100);
        beat(1'b1, 1'b0);
        check("sat_width", width_o, 4095);
        check("sat_height", height_o, 2);
        check("sat_line_err", line_err_o, 0);
        check("sat_fcnt", frame_cnt_o, 3);

        send_line(4, 1'b0, 1'b0);
        #3;
        ARESETn = 1'b0;
        #2;
        check("arst_fcnt", frame_cnt_o, 0);
        check("arst_valid", meas_valid_o, 0);
        #6;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        rand_clr = 1'b1;
        idle(2);
        for (int f = 0; f < 25; f++) begin
            stall_pct = $urandom_range(0, 60);
            h = $urandom_range(0, 6);
            w = $urandom_range(1, 12);
            if (h == 0) beat(1'b1, 1'b0);
            for (int i = 0; i < h; i++)
                send_line(($urandom_range(0, 9) == 0) ? $urandom_range(1, 14) : w, i == 0, 1'b1);
            if ($urandom_range(0, 9) == 0) send_line($urandom_range(1, 5), 1'b0, 1'b0);
        end
        beat(1'b1, 1'b0);
        rand_clr = 1'b0;
        idle(3);
        check("rand_valid", meas_valid_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
